// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial tap lookup, legal-order check and default seeds.
package prbs_pkg;

    localparam int unsigned PRBS_MAX_ORDER = 31;

    // Second tap of the primitive trinomial x^order + x^tap + 1; 0 marks an unsupported order.
    function automatic int unsigned prbs_tap(input int unsigned order);
        case (order)
            7:       return 6;
            9:       return 5;
            15:      return 14;
            23:      return 18;
            31:      return 28;
            default: return 0;
        endcase
    endfunction

    function automatic bit prbs_order_legal(input int unsigned order);
        return prbs_tap(order) != 0;
    endfunction

    function automatic logic [PRBS_MAX_ORDER-1:0] prbs_default_seed(input int unsigned order);
        logic [PRBS_MAX_ORDER-1:0] ones;
        ones = '1;
        return ones >> (PRBS_MAX_ORDER - order);
    endfunction

endpackage

// File: rtl/prbs_generator_if.sv
// Qualifier and bit-output bundle between a PRBS source and its consumer.
interface prbs_generator_if;
    logic i_enable;
    logic i_valid;
    logic o_prbsx;

    modport master (output i_enable, output i_valid, input o_prbsx);
    modport slave  (input i_enable, input i_valid, output o_prbsx);
endinterface

// File: rtl/prbs_lfsr_core.sv
// Fibonacci LFSR register: shifts toward the MSB, feedback enters at bit 0.
module prbs_lfsr_core #(
    parameter int unsigned      ORDER = 9,
    parameter int unsigned      TAP   = 5,
    parameter logic [ORDER-1:0] SEED  = '1
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_adv,
    output logic [ORDER-1:0] o_state
);

    logic [ORDER-1:0] sr_q;
    logic [ORDER-1:0] sr_d;
    logic             fb;

    always_comb begin
        fb   = sr_q[ORDER-1] ^ sr_q[TAP-1];
        sr_d = sr_q;
        if (i_adv) begin
            sr_d = {sr_q[ORDER-2:0], fb};
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            sr_q <= SEED;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign o_state = sr_q;

endmodule

// File: rtl/prbs_generator.sv
// PRBS bit source: one bit per qualified clock, MSB of the LFSR drives the output.
module prbs_generator
    import prbs_pkg::*;
#(
    parameter int unsigned      ORDER = 9,
    parameter logic [ORDER-1:0] SEEDX = 9'b110101010
) (
    input  logic              clock,
    input  logic              i_reset,
    prbs_generator_if.slave   bus
);

    localparam int unsigned                 TAP      = prbs_tap(ORDER);
    localparam logic [PRBS_MAX_ORDER-1:0]   DEF_SEED = prbs_default_seed(ORDER);
    // An all-zero seed would lock the LFSR, so it is swapped for all-ones.
    localparam logic [ORDER-1:0]            SEED_EFF = (SEEDX == '0) ? DEF_SEED[ORDER-1:0] : SEEDX;

    generate
        if (!prbs_order_legal(ORDER)) begin : g_bad_order
            $error("prbs_generator: unsupported ORDER %0d", ORDER);
        end
    endgenerate

    logic [ORDER-1:0] state;
    logic             adv;
    logic             unused_state_bits;

    assign adv = bus.i_enable & bus.i_valid;

    prbs_lfsr_core #(
        .ORDER (ORDER),
        .TAP   (TAP),
        .SEED  (SEED_EFF)
    ) u_core (
        .clock   (clock),
        .i_reset (i_reset),
        .i_adv   (adv),
        .o_state (state)
    );

    assign bus.o_prbsx       = state[ORDER-1];
    assign unused_state_bits = ^state[ORDER-2:0];

endmodule

// File: tb/tb_prbs_generator.sv
// Bench for prbs_generator: random stalls on an ORDER=9 instance plus free-running
// ORDER=7, ORDER=15 and zero-seed instances, all checked against a recurrence model.
module tb_prbs_generator;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_m = 1'b1;
    logic rst_o = 1'b1;

    prbs_generator_if bm ();
    prbs_generator_if bz ();
    prbs_generator_if b7 ();
    prbs_generator_if b15 ();

    prbs_generator #(.ORDER(9), .SEEDX(9'b110101010)) u_main (.clock(clock), .i_reset(rst_m), .bus(bm));
    prbs_generator #(.ORDER(9), .SEEDX(9'b000000000)) u_zero (.clock(clock), .i_reset(rst_o), .bus(bz));
    prbs_generator #(.ORDER(7), .SEEDX(7'h7f))        u_o7   (.clock(clock), .i_reset(rst_o), .bus(b7));
    prbs_generator #(.ORDER(15), .SEEDX(15'h7fff))    u_o15  (.clock(clock), .i_reset(rst_o), .bus(b15));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit gold9[];
    bit goldz[];
    bit gold7[];
    bit gold15[];
    bit qm[$];
    bit qz[$];
    bit q7[$];
    bit q15[$];
    bit sec_run = 0;
    bit collect = 0;

    int idx        = 0;
    int stall_left = 0;
    int stall_kind = 0;

    logic [8:0] seed9 = 9'b110101010;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s cycle budget expired at cycle %0d", tag, cyc);
    endtask

    // Output-bit recurrence of x^order + x^tap + 1: b[m] = b[m-order] ^ b[m-tap].
    task automatic build_gold(input int order, input int tap, input logic [30:0] seed,
                              input int len, output bit g[]);
        g = new[len];
        for (int i = 0; i < order; i++) g[i] = seed[order-1-i];
        for (int m = order; m < len; m++) g[m] = g[m-order] ^ g[m-tap];
    endtask

    function automatic int count_ones(input bit s[$], input int from, input int len);
        int n = 0;
        for (int i = from; i < from + len; i++) n += int'(s[i]);
        return n;
    endfunction

    function automatic int window_hits(input bit s[$], input int order, input logic [30:0] pat,
                                       input int first, input int last);
        int hits = 0;
        for (int p = first; p <= last; p++) begin
            logic [30:0] v = '0;
            for (int k = 0; k < order; k++) v = {v[29:0], s[p+k]};
            if (v == pat) hits++;
        end
        return hits;
    endfunction

    function automatic int mismatches(input bit s[$], input bit g[], input int len);
        int n = 0;
        for (int i = 0; i < len; i++) if (s[i] != g[i]) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        cyc++;
        if (sec_run) begin
            qz.push_back(bz.o_prbsx);
            q7.push_back(b7.o_prbsx);
            q15.push_back(b15.o_prbsx);
        end
    endtask

    task automatic drive_random();
        if (stall_left == 0 && $urandom_range(0, 4) == 0) begin
            stall_left = $urandom_range(1, 5);
            stall_kind = $urandom_range(0, 1);
        end
        if (stall_left > 0) begin
            stall_left--;
            if (stall_kind == 0) begin
                bm.i_enable = 1'b1;
                bm.i_valid  = 1'b0;
            end else begin
                bm.i_enable = 1'b0;
                bm.i_valid  = 1'($urandom_range(0, 1));
            end
        end else begin
            bm.i_enable = 1'b1;
            bm.i_valid  = 1'b1;
        end
    endtask

    // One main-stream cycle: check current bit, pick qualifiers, advance the model index on a qualified edge.
    task automatic main_cycle();
        bit q;
        chk("stream", 32'(bm.o_prbsx), 32'(gold9[idx]));
        drive_random();
        q = bm.i_enable & bm.i_valid;
        if (q && collect) qm.push_back(bm.o_prbsx);
        step();
        if (q) idx++;
    endtask

    initial begin
        int guard;
        logic [30:0] all_ones;
        all_ones = '1;

        build_gold(9, 5, 31'(seed9), 1100, gold9);
        build_gold(9, 5, 31'h1ff, 600, goldz);
        build_gold(7, 6, 31'h7f, 200, gold7);
        build_gold(15, 14, 31'h7fff, 32800, gold15);

        bm.i_enable = 1'b0; bm.i_valid = 1'b0;
        bz.i_enable = 1'b0; bz.i_valid = 1'b0;
        b7.i_enable = 1'b0; b7.i_valid = 1'b0;
        b15.i_enable = 1'b0; b15.i_valid = 1'b0;

        @(negedge clock);
        step();
        step();
        chk("rst_main", 32'(bm.o_prbsx), 32'(seed9[8]));
        chk("rst_zero", 32'(bz.o_prbsx), 32'd1);
        chk("rst_o7",   32'(b7.o_prbsx), 32'd1);
        chk("rst_o15",  32'(b15.o_prbsx), 32'd1);

        // Release; secondaries free-run, main held with enable low.
        rst_m = 1'b0; rst_o = 1'b0;
        bz.i_enable = 1'b1; bz.i_valid = 1'b1;
        b7.i_enable = 1'b1; b7.i_valid = 1'b1;
        b15.i_enable = 1'b1; b15.i_valid = 1'b1;
        bm.i_enable = 1'b0; bm.i_valid = 1'b1;
        sec_run = 1;
        qz.push_back(bz.o_prbsx);
        q7.push_back(b7.o_prbsx);
        q15.push_back(b15.o_prbsx);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_en_low", 32'(bm.o_prbsx), 32'(gold9[0]));
        end

        guard = 0;
        while (idx < 37) begin
            main_cycle();
            if (++guard > 2000) begin timeout("run_to_37"); break; end
        end
        chk("bit37", 32'(bm.o_prbsx), 32'(gold9[37]));

        rst_m = 1'b1; bm.i_enable = 1'b1; bm.i_valid = 1'b1;
        step();
        rst_m = 1'b0;
        idx = 0;
        stall_left = 0;
        chk("restart_bit", 32'(bm.o_prbsx), 32'(seed9[8]));

        collect = 1;
        guard = 0;
        while (qm.size() < 520) begin
            main_cycle();
            if (++guard > 5000) begin timeout("main_period"); break; end
        end
        bm.i_enable = 1'b0; bm.i_valid = 1'b0;

        guard = 0;
        while (q15.size() < 32782) begin
            step();
            if (++guard > 40000) begin timeout("o15_run"); break; end
        end

        if (qm.size() >= 520) begin
            chk("seed_bits",    32'(window_hits(qm, 9, 31'(seed9), 0, 0)), 32'd1);
            chk("main_first20", 32'(mismatches(qm, gold9, 20)), 32'd0);
            chk("main_return",  32'(window_hits(qm, 9, 31'(seed9), 511, 511)), 32'd1);
            chk("main_norepeat", 32'(window_hits(qm, 9, 31'(seed9), 1, 510)), 32'd0);
            chk("main_ones",    32'(count_ones(qm, 0, 511)), 32'd256);
        end

        chk("zero_first9",  32'(window_hits(qz, 9, all_ones >> 22, 0, 0)), 32'd1);
        chk("zero_stream",  32'(mismatches(qz, goldz, 520)), 32'd0);
        chk("zero_ones",    32'(count_ones(qz, 0, 511)), 32'd256);
        chk("zero_return",  32'(window_hits(qz, 9, all_ones >> 22, 511, 511)), 32'd1);

        chk("o7_stream",    32'(mismatches(q7, gold7, 134)), 32'd0);
        chk("o7_return",    32'(window_hits(q7, 7, all_ones >> 24, 127, 127)), 32'd1);
        chk("o7_norepeat",  32'(window_hits(q7, 7, all_ones >> 24, 1, 126)), 32'd0);
        chk("o7_ones",      32'(count_ones(q7, 0, 127)), 32'd64);

        if (q15.size() >= 32782) begin
            chk("o15_stream",   32'(mismatches(q15, gold15, 32782)), 32'd0);
            chk("o15_return",   32'(window_hits(q15, 15, all_ones >> 16, 32767, 32767)), 32'd1);
            chk("o15_norepeat", 32'(window_hits(q15, 15, all_ones >> 16, 1, 32766)), 32'd0);
            chk("o15_ones",     32'(count_ones(q15, 0, 32767)), 32'd16384);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
